mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one serial-input multiplier between `NUM_REQ` requesters. It accepts a request with both operands and drives the multiplier's start / operand-A / operand-B sequence. It then waits for `done`, with a timeout, and returns the product to the granted requester. It sits between the requester blocks and the multiplier's DUT modport.

---
 rtl/mult_arbiter.sv | 151 +++++++++++++++
 tb/tb_mult_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sequencing NUM_REQ requesters onto one serial-input multiplier (start, A, B, wait done).
// Grant one cycle after a request is seen in IDLE, response one cycle after done or TIMEOUT; other requests wait while busy.
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] a_i,
    input  logic [NUM_REQ*DATA_W-1:0] b_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [2*DATA_W-1:0]       rsp_data_o,
    output logic                      rsp_err_o,
    output logic                      busy_o,
    output logic                      mul_start_o,
    output logic [DATA_W-1:0]         mul_data_o,
    input  logic                      mul_done_i,
    input  logic [2*DATA_W-1:0]       mul_data_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SEND_A, S_SEND_B, S_WAIT_DONE, S_RESP
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_ptr, r_idx, w_sel;
    logic                w_sel_vld;
    int                  w_idx;
    logic [DATA_W-1:0]   w_sel_a, w_sel_b, r_a, r_b;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_timeout;
    logic [NUM_REQ-1:0]  r_gnt, r_rsp_vld, w_gnt_nxt, w_rsp_vld_nxt;
    logic [2*DATA_W-1:0] r_result, w_result_nxt;
    logic                r_err, r_busy, r_start;
    logic                w_err_nxt, w_busy_nxt, w_start_nxt;
    logic [DATA_W-1:0]   r_mul_data, w_mul_data_nxt;

    // First requester at or after r_ptr, wrapping around.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel     = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = (int'(r_ptr) + i) % NUM_REQ;
            if (!w_sel_vld && req_i[w_idx]) begin
                w_sel_vld = 1'b1;
                w_sel     = IDX_W'(w_idx);
                w_sel_a   = a_i[w_idx*DATA_W +: DATA_W];
                w_sel_b   = b_i[w_idx*DATA_W +: DATA_W];
            end
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_sel_vld) w_state_nxt = S_START;
            S_START:     w_state_nxt = S_SEND_A;
            S_SEND_A:    w_state_nxt = S_SEND_B;
            S_SEND_B:    w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (mul_done_i || w_timeout) w_state_nxt = S_RESP;
            S_RESP:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed for the upcoming state so every port comes straight from a flop.
    always_comb begin
        w_gnt_nxt      = '0;
        w_rsp_vld_nxt  = '0;
        w_start_nxt    = 1'b0;
        w_err_nxt      = 1'b0;
        w_mul_data_nxt = '0;
        w_result_nxt   = r_result;
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        if (w_state_nxt == S_START) begin
            w_gnt_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
            w_start_nxt = 1'b1;
        end
        if (w_state_nxt == S_SEND_A) w_mul_data_nxt = r_a;
        if (w_state_nxt == S_SEND_B) w_mul_data_nxt = r_b;
        if (r_state == S_WAIT_DONE && w_state_nxt == S_RESP) begin
            w_rsp_vld_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_idx;
            w_err_nxt     = !mul_done_i;
            w_result_nxt  = mul_done_i ? mul_data_i : '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_ptr      <= '0;
            r_idx      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_gnt      <= '0;
            r_rsp_vld  <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_start    <= 1'b0;
            r_mul_data <= '0;
        end else begin
            if (r_state == S_IDLE && w_sel_vld) begin
                r_idx <= w_sel;
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
                r_ptr <= (w_sel == IDX_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
            end
            if (r_state == S_SEND_B) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT_DONE) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_result   <= w_result_nxt;
            r_gnt      <= w_gnt_nxt;
            r_rsp_vld  <= w_rsp_vld_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= w_busy_nxt;
            r_start    <= w_start_nxt;
            r_mul_data <= w_mul_data_nxt;
        end
    end

    assign gnt_o       = r_gnt;
    assign rsp_valid_o = r_rsp_vld;
    assign rsp_data_o  = r_result;
    assign rsp_err_o   = r_err;
    assign busy_o      = r_busy;
    assign mul_start_o = r_start;
    assign mul_data_o  = r_mul_data;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: a transaction timeline model predicts every output per cycle,
// directed phases plus a random phase drive requesters and a multiplier stand-in.
module tb_mult_arbiter;
    localparam int NR = 4;
    localparam int DW = 4;
    localparam int TO = 8;
    localparam int NE = 4096;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic              rst_in;
    logic [NR-1:0]     req_i;
    logic [NR*DW-1:0]  a_i, b_i;
    logic [NR-1:0]     gnt_o, rsp_valid_o;
    logic [2*DW-1:0]   rsp_data_o;
    logic              rsp_err_o, busy_o, mul_start_o;
    logic [DW-1:0]     mul_data_o;
    logic              mul_done_i;
    logic [2*DW-1:0]   mul_data_i;

    mult_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .req_i(req_i), .a_i(a_i), .b_i(b_i),
        .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o), .busy_o(busy_o), .mul_start_o(mul_start_o),
        .mul_data_o(mul_data_o), .mul_done_i(mul_done_i), .mul_data_i(mul_data_i)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected outputs indexed by the edge after which they become visible.
    bit [NR-1:0]   e_gnt[NE], e_rsp[NE];
    bit            e_start[NE], e_err[NE], e_busy[NE], e_dset[NE], done_at[NE];
    bit [DW-1:0]   e_mdat[NE];
    bit [2*DW-1:0] e_dval[NE];
    bit [2*DW-1:0] cur_data;

    bit [NR-1:0] pend;
    bit [DW-1:0] pa[NR], pb[NR];
    int ptr_m = 0, free_e = 0, act_n = -100, act_m = -100;
    bit [DW-1:0] act_a, act_b;
    int raise_pct = 0, noise_pct = 0, force_d = 0;
    bit rst_drv;

    int            obs_gnt[$], obs_gnt_cyc[$], obs_rsp_cyc[$];
    bit [2*DW-1:0] obs_rsp_data[$];
    bit            obs_rsp_err[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic clear_obs();
        obs_gnt.delete(); obs_gnt_cyc.delete(); obs_rsp_cyc.delete();
        obs_rsp_data.delete(); obs_rsp_err.delete();
    endtask

    task automatic drive();
        bit in_win;
        for (int k = 0; k < NR; k++) begin
            if (!pend[k] && int'($urandom_range(99)) < raise_pct) begin
                pend[k] = 1'b1;
                pa[k]   = DW'($urandom);
                pb[k]   = DW'($urandom);
            end
        end
        rst_in = rst_drv;
        req_i  = pend;
        for (int k = 0; k < NR; k++) begin
            a_i[k*DW +: DW] = pa[k];
            b_i[k*DW +: DW] = pb[k];
        end
        in_win = (cyc >= act_n + 4) && (cyc <= act_m);
        if (done_at[cyc]) begin
            mul_done_i = 1'b1;
            mul_data_i = act_a * act_b;
        end else begin
            mul_done_i = !in_win && (int'($urandom_range(99)) < noise_pct);
            mul_data_i = (2*DW)'($urandom);
        end
    endtask

    // Transaction-level model: on issue at edge n, lay out the whole response timeline.
    task automatic model();
        int e, k, d, m;
        e = cyc;
        if (!rst_drv) begin
            for (int j = e; j < e + TO + 16 && j < NE; j++) begin
                e_gnt[j] = '0; e_rsp[j] = '0; e_start[j] = 0; e_err[j] = 0;
                e_busy[j] = 0; e_dset[j] = 0; done_at[j] = 0; e_mdat[j] = '0;
            end
            e_dset[e] = 1; e_dval[e] = '0;
            ptr_m = 0; free_e = e + 1; act_n = -100; act_m = -100;
        end else if (e >= free_e && req_i != '0) begin
            k = -1;
            for (int i = 0; i < NR; i++) begin
                if (k < 0 && req_i[(ptr_m + i) % NR]) k = (ptr_m + i) % NR;
            end
            if (force_d != 0) d = force_d;
            else begin
                case ($urandom_range(9))
                    7:       d = TO;
                    8:       d = TO + 1;
                    9:       d = int'($urandom_range(1, TO));
                    default: d = int'($urandom_range(1, 5));
                endcase
            end
            ptr_m = (k + 1) % NR;
            act_n = e; act_a = pa[k]; act_b = pb[k];
            e_gnt[e] = NR'(1) << k;
            e_start[e] = 1;
            e_mdat[e+1] = act_a;
            e_mdat[e+2] = act_b;
            if (d <= TO) begin
                m = e + 3 + d;
                done_at[m] = 1;
                e_err[m] = 0;
                e_dval[m] = act_a * act_b;
            end else begin
                m = e + 3 + TO;
                e_err[m] = 1;
                e_dval[m] = '0;
            end
            e_rsp[m] = NR'(1) << k;
            e_dset[m] = 1;
            for (int j = e; j <= m; j++) e_busy[j] = 1;
            act_m = m; free_e = m + 2;
            pend[k] = 1'b0;
        end
    endtask

    task automatic check_cycle();
        int e;
        e = cyc;
        if (e_dset[e]) cur_data = e_dval[e];
        check_val("gnt",       32'(gnt_o),       32'(e_gnt[e]));
        check_val("rsp_valid", 32'(rsp_valid_o), 32'(e_rsp[e]));
        check_val("rsp_data",  32'(rsp_data_o),  32'(cur_data));
        check_val("rsp_err",   32'(rsp_err_o),   32'(e_err[e]));
        check_val("busy",      32'(busy_o),      32'(e_busy[e]));
        check_val("mul_start", 32'(mul_start_o), 32'(e_start[e]));
        check_val("mul_data",  32'(mul_data_o),  32'(e_mdat[e]));
        if (gnt_o != '0) begin
            obs_gnt.push_back(oh_idx(gnt_o));
            obs_gnt_cyc.push_back(e);
        end
        if (rsp_valid_o != '0) begin
            obs_rsp_cyc.push_back(e);
            obs_rsp_data.push_back(rsp_data_o);
            obs_rsp_err.push_back(rsp_err_o);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
        drive();
        @(posedge clk_in);
        model();
        #1;
        check_cycle();
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        rst_in = 1'b0; rst_drv = 1'b0; pend = '0;
        req_i = '0; a_i = '0; b_i = '0; mul_done_i = 1'b0; mul_data_i = '0;
        run(2);
        rst_drv = 1'b1;

        // Fairness: everyone requesting continuously.
        clear_obs();
        pa[0] = 15; pb[0] = 15; pa[1] = 0; pb[1] = 9;
        pa[2] = 7;  pb[2] = 6;  pa[3] = 10; pb[3] = 12;
        pend = 4'b1111; raise_pct = 100; force_d = 2;
        run(40);
        check_val("fair_count", 32'(obs_gnt.size() >= 5), 32'd1);
        if (obs_gnt.size() >= 5) begin
            check_val("fair_g0", obs_gnt[0], 0);
            check_val("fair_g1", obs_gnt[1], 1);
            check_val("fair_g2", obs_gnt[2], 2);
            check_val("fair_g3", obs_gnt[3], 3);
            check_val("fair_g4", obs_gnt[4], 0);
        end
        if (obs_rsp_data.size() >= 4) begin
            check_val("fair_p0", 32'(obs_rsp_data[0]), 225);
            check_val("fair_p1", 32'(obs_rsp_data[1]), 0);
            check_val("fair_p2", 32'(obs_rsp_data[2]), 42);
            check_val("fair_p3", 32'(obs_rsp_data[3]), 120);
        end
        raise_pct = 0;
        run(60);

        // Single request, done four cycles after B.
        clear_obs();
        pa[0] = 3; pb[0] = 5; pend = 4'b0001; force_d = 4;
        run(14);
        check_val("single_rsp_count", obs_rsp_cyc.size(), 1);
        if (obs_rsp_cyc.size() == 1 && obs_gnt.size() == 1) begin
            check_val("single_gnt", obs_gnt[0], 0);
            check_val("single_data", 32'(obs_rsp_data[0]), 15);
            check_val("single_err", 32'(obs_rsp_err[0]), 0);
            check_val("single_latency", obs_rsp_cyc[0] - obs_gnt_cyc[0], 7);
        end

        // Pointer rotation after serving requester 2.
        pa[2] = 6; pb[2] = 7; pend = 4'b0100; force_d = 1;
        run(10);
        clear_obs();
        pend = 4'b1010;
        run(20);
        check_val("ptr_count", obs_gnt.size(), 2);
        if (obs_gnt.size() == 2) begin
            check_val("ptr_first", obs_gnt[0], 3);
            check_val("ptr_second", obs_gnt[1], 1);
        end

        // Timeout, then stray done pulses while idle.
        clear_obs();
        pa[0] = 9; pb[0] = 9; pend = 4'b0001; force_d = TO + 1;
        run(TO + 6);
        noise_pct = 50;
        run(10);
        noise_pct = 0;
        check_val("to_rsp_count", obs_rsp_cyc.size(), 1);
        if (obs_rsp_cyc.size() == 1 && obs_gnt.size() == 1) begin
            check_val("to_latency", obs_rsp_cyc[0] - obs_gnt_cyc[0], 11);
            check_val("to_err", 32'(obs_rsp_err[0]), 1);
            check_val("to_data", 32'(obs_rsp_data[0]), 0);
        end

        // Stale done while idle and while sending operands.
        clear_obs();
        noise_pct = 60; pa[1] = 9; pb[1] = 9; pend = 4'b0010; force_d = 3;
        run(12);
        noise_pct = 0;
        run(4);
        check_val("stale_rsp_count", obs_rsp_cyc.size(), 1);
        if (obs_rsp_cyc.size() == 1) check_val("stale_data", 32'(obs_rsp_data[0]), 81);

        // Reset during WAIT_DONE abandons the transaction and clears the pointer.
        clear_obs();
        pend = 4'b0100; force_d = TO + 1;
        run(6);
        rst_drv = 1'b0;
        step();
        check_val("rst_outputs",
                  32'({gnt_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o, mul_start_o, mul_data_o}), 0);
        rst_drv = 1'b1;
        run(15);
        check_val("rst_no_rsp", obs_rsp_cyc.size(), 0);
        clear_obs();
        pend = 4'b1001; force_d = 1;
        run(16);
        check_val("rst_ptr_count", obs_gnt.size(), 2);
        if (obs_gnt.size() == 2) begin
            check_val("rst_ptr_first", obs_gnt[0], 0);
            check_val("rst_ptr_second", obs_gnt[1], 3);
        end

        // Random traffic with random done latency, ties, timeouts and stray done pulses.
        raise_pct = 30; noise_pct = 20; force_d = 0;
        run(1500);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
